// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard/forwarding control with dcache-wait FSM and sticky halt
// Optional stall/flush counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl_unit #(
    parameter int WAIT_LIMIT = 1023,
    parameter int CNT_W      = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic [4:0] de_rs,
    input  logic [4:0] de_rt,
    input  logic [4:0] de_wsel,
    input  logic       de_regwr,
    input  logic       de_dren,
    input  logic [4:0] em_wsel,
    input  logic       em_regwr,
    input  logic       em_dren,
    input  logic       em_dwen,
    input  logic [4:0] mw_wsel,
    input  logic       mw_regwr,
    input  logic       mw_halt,
    input  logic       ex_redirect,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_en,
    output logic       em_en,
    output logic       mw_en,
    output logic       fd_flush,
    output logic       de_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic       mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DWAIT,
        ST_HALTED
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT_C = CNT_W'(WAIT_LIMIT);

    state_t           fsm_q, fsm_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             halted_q, halted_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic       mem_busy;
    logic       load_use;
    logic       redirect_applied;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    assign mem_busy = (em_dren | em_dwen) & ~dhit;
    assign load_use = de_dren & de_regwr & (de_wsel != 5'd0) &
                      ((de_wsel == fd_rs) | (de_wsel == fd_rt));

    // A load in EM has no ALU result to forward, so it falls through to MW.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (em_regwr && !em_dren && em_wsel != 5'd0 && em_wsel == de_rs)
            fwd_a_sel = 2'b01;
        else if (mw_regwr && mw_wsel != 5'd0 && mw_wsel == de_rs)
            fwd_a_sel = 2'b10;
        if (em_regwr && !em_dren && em_wsel != 5'd0 && em_wsel == de_rt)
            fwd_b_sel = 2'b01;
        else if (mw_regwr && mw_wsel != 5'd0 && mw_wsel == de_rt)
            fwd_b_sel = 2'b10;
    end

    always_comb begin
        pc_en            = 1'b0;
        fd_en            = 1'b0;
        de_en            = 1'b0;
        em_en            = 1'b0;
        mw_en            = 1'b0;
        fd_flush         = 1'b0;
        de_flush         = 1'b0;
        fwd_a            = 2'b00;
        fwd_b            = 2'b00;
        redirect_applied = 1'b0;
        if (!RST && fsm_q != ST_HALTED) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (mem_busy) begin
                pc_en = 1'b0;
            end else if (ex_redirect) begin
                {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                fd_flush         = 1'b1;
                de_flush         = 1'b1;
                redirect_applied = 1'b1;
            end else if (load_use || !ihit) begin
                {de_en, em_en, mw_en} = 3'b111;
                de_flush = 1'b1;
            end else begin
                {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
            end
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        wait_cnt_d    = wait_cnt_q;
        halted_d      = halted_q;
        mem_timeout_d = mem_timeout_q | (wait_cnt_q == WAIT_LIMIT_C);
        case (fsm_q)
            ST_RUN: begin
                if (mem_busy) begin
                    fsm_d      = ST_DWAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_DWAIT: begin
                if (dhit) begin
                    fsm_d      = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                fsm_d = ST_HALTED;
            end
        endcase
        // The halting instruction must actually retire, so gate on mw_en.
        if (fsm_q != ST_HALTED && mw_halt && mw_en) begin
            fsm_d      = ST_HALTED;
            halted_d   = 1'b1;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q         <= ST_RUN;
            wait_cnt_q    <= '0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            wait_cnt_q    <= wait_cnt_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign halted      = halted_q;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (fsm_q != ST_HALTED && !pc_en)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (redirect_applied)
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    localparam int WAIT_LIMIT = 3;
    localparam int CNT_W      = 3;

    logic       CLK;
    logic       RST;
    logic       ihit, dhit;
    logic [4:0] fd_rs, fd_rt, de_rs, de_rt, de_wsel, em_wsel, mw_wsel;
    logic       de_regwr, de_dren, em_regwr, em_dren, em_dwen;
    logic       mw_regwr, mw_halt, ex_redirect;
    logic       pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       halted, mem_timeout;

    hazard_ctrl_unit #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .de_rs(de_rs), .de_rt(de_rt),
        .de_wsel(de_wsel), .de_regwr(de_regwr), .de_dren(de_dren),
        .em_wsel(em_wsel), .em_regwr(em_regwr), .em_dren(em_dren), .em_dwen(em_dwen),
        .mw_wsel(mw_wsel), .mw_regwr(mw_regwr), .mw_halt(mw_halt),
        .ex_redirect(ex_redirect),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .mem_timeout(mem_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] exp_q[$];

    // Reference model state: 0 = run, 1 = dcache wait, 2 = halted
    int m_state;
    int m_cnt;
    logic m_halted, m_to;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (em_regwr && !em_dren && em_wsel == src) return 2'b01;
        if (mw_regwr && mw_wsel == src) return 2'b10;
        return 2'b00;
    endfunction

    // Packed as {pc,fd,de,em,mw,fd_flush,de_flush,fwd_a,fwd_b,halted,mem_timeout}
    function automatic logic [12:0] ref_out();
        logic [6:0] ctl;
        logic busy, lu;
        busy = (em_dren || em_dwen) && !dhit;
        lu = de_dren && de_regwr && de_wsel != 5'd0 && (de_wsel == fd_rs || de_wsel == fd_rt);
        if (RST || m_state == 2) return {11'b0, m_halted, m_to};
        if (busy)            ctl = 7'b0000000;
        else if (ex_redirect) ctl = 7'b1111111;
        else if (lu || !ihit) ctl = 7'b0011101;
        else                  ctl = 7'b1111100;
        return {ctl, ref_fwd(de_rs), ref_fwd(de_rt), m_halted, m_to};
    endfunction

    task automatic ref_update(input logic mw_en_exp);
        logic busy;
        logic nto;
        busy = (em_dren || em_dwen) && !dhit;
        if (RST) begin
            m_state = 0; m_cnt = 0; m_halted = 1'b0; m_to = 1'b0;
        end else begin
            nto = m_to || (m_cnt == WAIT_LIMIT);
            if (m_state != 2 && mw_halt && mw_en_exp) begin
                m_state = 2; m_halted = 1'b1; m_cnt = 0;
            end else if (m_state == 0 && busy) begin
                m_state = 1; m_cnt = 1;
            end else if (m_state == 1) begin
                if (dhit) begin
                    m_state = 0; m_cnt = 0;
                end else if (m_cnt < (1 << CNT_W) - 1) begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_to = nto;
        end
    endtask

    task automatic step(input string tag);
        logic [12:0] e;
        logic [12:0] got;
        exp_q.push_back(ref_out());
        #2;
        got = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush,
               fwd_a, fwd_b, halted, mem_timeout};
        e = exp_q.pop_front();
        check_eq(tag, {19'd0, got}, {19'd0, e});
        @(posedge CLK);
        ref_update(e[8]);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0;
        fd_rs = 5'd0; fd_rt = 5'd0; de_rs = 5'd0; de_rt = 5'd0; de_wsel = 5'd0;
        de_regwr = 1'b0; de_dren = 1'b0;
        em_wsel = 5'd0; em_regwr = 1'b0; em_dren = 1'b0; em_dwen = 1'b0;
        mw_wsel = 5'd0; mw_regwr = 1'b0; mw_halt = 1'b0; ex_redirect = 1'b0;
    endtask

    initial begin
        m_state = 0; m_cnt = 0; m_halted = 1'b0; m_to = 1'b0;
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        step("reset_0");
        step("reset_1");
        RST = 1'b0;
        step("idle_run");

        de_dren = 1'b1; de_regwr = 1'b1; de_wsel = 5'd8; fd_rs = 5'd8;
        step("load_use_rs");
        fd_rs = 5'd0; fd_rt = 5'd8;
        step("load_use_rt");
        de_wsel = 5'd0; fd_rt = 5'd0;
        step("load_use_r0");
        idle_inputs();

        em_wsel = 5'd5; mw_wsel = 5'd5; de_rs = 5'd5; de_rt = 5'd5;
        em_regwr = 1'b1; mw_regwr = 1'b1;
        step("fwd_em_wins");
        em_dren = 1'b1; dhit = 1'b1;
        step("fwd_load_mw");
        de_rs = 5'd0; de_rt = 5'd0; em_wsel = 5'd0; mw_wsel = 5'd0;
        step("fwd_r0");
        idle_inputs();

        ex_redirect = 1'b1; ihit = 1'b0;
        step("redirect_miss");
        em_dwen = 1'b1;
        step("redirect_busy");
        dhit = 1'b1;
        step("redirect_on_dhit");
        idle_inputs();

        em_dren = 1'b1;
        for (int i = 0; i < 6; i++) step("dwait");
        dhit = 1'b1;
        step("dwait_release");
        idle_inputs();
        step("timeout_sticky");

        for (int i = 0; i < 40; i++) begin
            ihit = 1'($urandom_range(0, 3) != 0);
            dhit = 1'($urandom_range(0, 1));
            fd_rs = 5'($urandom_range(0, 3)); fd_rt = 5'($urandom_range(0, 3));
            de_rs = 5'($urandom_range(0, 3)); de_rt = 5'($urandom_range(0, 3));
            de_wsel = 5'($urandom_range(0, 3));
            de_regwr = 1'($urandom_range(0, 1)); de_dren = 1'($urandom_range(0, 1));
            em_wsel = 5'($urandom_range(0, 3)); em_regwr = 1'($urandom_range(0, 1));
            em_dren = 1'($urandom_range(0, 3) == 0); em_dwen = 1'($urandom_range(0, 3) == 0);
            mw_wsel = 5'($urandom_range(0, 3)); mw_regwr = 1'($urandom_range(0, 1));
            ex_redirect = 1'($urandom_range(0, 3) == 0);
            step("random");
        end

        idle_inputs();
        dhit = 1'b1;
        step("settle");
        mw_halt = 1'b1;
        step("halt_retire");
        for (int i = 0; i < 3; i++) begin
            ex_redirect = 1'($urandom_range(0, 1));
            em_dren = 1'($urandom_range(0, 1));
            de_rs = 5'd5; em_wsel = 5'd5; em_regwr = 1'b1;
            step("halted_hold");
        end
        RST = 1'b1;
        step("halt_rst");
        RST = 1'b0;
        idle_inputs();
        step("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
